exreg_byte_store: RTL and testbench

// - Streams the low N bytes of a 256-bit extended register out to byte-addressed data memory, one byte per accepted write.
// - Inverse of the exalu byte-load op, which shifts bytes into a 256-bit register (D1<<8 | byte), so the first byte loaded becomes the most significant.
// - Sits beside exalu as a multi-cycle responder: the core raises we and waits while busy is high, the same pattern used for the aes/invAes units.

---
 rtl/exreg_byte_store.sv | 75 +++++++
 tb/tb_exreg_byte_store.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/exreg_byte_store.sv
// exreg_byte_store: streams the low N bytes of a wide register to byte memory,
// most significant byte first, one byte per accepted write.
module exreg_byte_store #(
    parameter int DATA_WIDTH = 256,
    parameter int ADDR_WIDTH = 32,
    parameter int MAX_BYTES = DATA_WIDTH / 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  we,
    input  logic [DATA_WIDTH-1:0] src,
    input  logic [ADDR_WIDTH-1:0] baseAddr,
    input  logic [5:0]            byteCount,
    output logic                  busy,
    output logic                  done,
    output logic                  memWE,
    output logic [ADDR_WIDTH-1:0] memAddr,
    output logic [7:0]            memWData,
    input  logic                  memReady
);
    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;
    state_t state, nextState;
    logic wePrev;
    logic start;
    logic accept;
    logic [5:0] nClamp;
    logic [5:0] remaining;
    logic [DATA_WIDTH-1:0] shiftReg;
    logic [ADDR_WIDTH-1:0] addrReg;

    assign start = we && !wePrev;
    assign accept = memWE && memReady;
    assign nClamp = (byteCount > 6'(MAX_BYTES)) ? 6'(MAX_BYTES) : byteCount;

    // The first byte to emit is left-aligned so every accept is a plain shift by 8.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            wePrev <= 1'b0;
            shiftReg <= '0;
            addrReg <= '0;
            remaining <= '0;
        end else begin
            state <= nextState;
            wePrev <= we;
            if (state == IDLE && start) begin
                shiftReg <= src << {6'(MAX_BYTES) - nClamp, 3'b000};
                addrReg <= baseAddr;
                remaining <= nClamp;
            end else if (accept) begin
                shiftReg <= shiftReg << 8;
                addrReg <= addrReg + ADDR_WIDTH'(1);
                remaining <= remaining - 6'd1;
            end
        end
    end

    always_comb begin
        nextState = state;
        if (state == IDLE && start)
            nextState = (nClamp == 6'd0) ? DONE : WRITE;
        else if (state == WRITE && accept && remaining == 6'd1)
            nextState = DONE;
        else if (state == DONE)
            nextState = IDLE;
    end

    always_comb begin
        busy = state == WRITE;
        done = state == DONE;
        memWE = busy;
        memAddr = busy ? addrReg : '0;
        memWData = busy ? shiftReg[DATA_WIDTH-1 -: 8] : 8'h00;
    end
endmodule

// File: tb/tb_exreg_byte_store.sv
// tb_exreg_byte_store: directed stimulus with a scoreboard of expected memory
// writes and done pulses, each tagged with the clock edge it must occur on.
module tb_exreg_byte_store;
    localparam int DW = 256;
    localparam int AW = 32;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic we = 1'b0;
    logic memReady = 1'b1;
    logic [DW-1:0] src = '0;
    logic [AW-1:0] baseAddr = '0;
    logic [5:0] byteCount = '0;
    logic busy, done, memWE;
    logic [AW-1:0] memAddr;
    logic [7:0] memWData;

    typedef struct {
        bit isDone;
        logic [AW-1:0] addr;
        logic [7:0] data;
        int edgeNum;
    } exp_t;

    exp_t sb[$];
    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int startCyc = 0;

    exreg_byte_store dut (
        .clock(clock), .reset(reset), .we(we), .src(src), .baseAddr(baseAddr),
        .byteCount(byteCount), .busy(busy), .done(done), .memWE(memWE),
        .memAddr(memAddr), .memWData(memWData), .memReady(memReady)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: events seen after edge k are taken by the core on edge k+1.
    always @(negedge clock) begin
        exp_t e;
        if (!reset) begin
            if (memWE && !memReady && sb.size() > 0 && !sb[0].isDone) begin
                checks++;
                if (memAddr !== sb[0].addr || memWData !== sb[0].data) begin
                    errors++;
                    $display("FAIL hold: addr %h data %h, required addr %h data %h",
                             memAddr, memWData, sb[0].addr, sb[0].data);
                end
            end
            if (memWE && memReady) begin
                checks++;
                if (sb.size() == 0 || sb[0].isDone) begin
                    errors++;
                    $display("FAIL write: unexpected write addr %h data %h at edge %0d",
                             memAddr, memWData, cyc + 1);
                end else begin
                    e = sb.pop_front();
                    if (memAddr !== e.addr || memWData !== e.data || cyc + 1 != e.edgeNum) begin
                        errors++;
                        $display("FAIL write: addr %h data %h edge %0d, required addr %h data %h edge %0d",
                                 memAddr, memWData, cyc + 1, e.addr, e.data, e.edgeNum);
                    end
                end
            end
            if (done) begin
                checks++;
                if (sb.size() == 0 || !sb[0].isDone) begin
                    errors++;
                    $display("FAIL done: unexpected done pulse at edge %0d", cyc + 1);
                end else begin
                    e = sb.pop_front();
                    if (cyc + 1 != e.edgeNum) begin
                        errors++;
                        $display("FAIL done: at edge %0d, required edge %0d", cyc + 1, e.edgeNum);
                    end
                end
            end
        end
    end

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic chk(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic startOp(logic [DW-1:0] s, logic [AW-1:0] b, logic [5:0] n);
        src = s;
        baseAddr = b;
        byteCount = n;
        we = 1'b1;
        startCyc = cyc + 1;
    endtask

    task automatic pushWr(int rel, logic [AW-1:0] a, logic [7:0] d);
        sb.push_back('{1'b0, a, d, startCyc + rel});
    endtask

    task automatic pushDone(int rel);
        sb.push_back('{1'b1, '0, 8'h00, startCyc + rel});
    endtask

    task automatic drain(string name, int maxCyc);
        for (int i = 0; i < maxCyc && sb.size() > 0; i++) tick();
        tick(3);
        chk({name, " drained"}, 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    initial begin
        logic [DW-1:0] ramp;
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] ramp;
        tick(2);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset memWE", 64'(memWE), 64'd0);
        chk("reset memAddr", 64'(memAddr), 64'd0);
        chk("reset memWData", 64'(memWData), 64'd0);
        reset = 1'b0;
        tick(2);

        // Four bytes, memory always ready.
        startOp(256'hDEADBEEF, 32'h100, 6'd4);
        pushWr(1, 32'h100, 8'hDE);
        pushWr(2, 32'h101, 8'hAD);
        pushWr(3, 32'h102, 8'hBE);
        pushWr(4, 32'h103, 8'hEF);
        pushDone(5);
        tick();
        we = 1'b0;
        chk("busy first write", 64'(busy), 64'd1);
        drain("basic", 20);

        // Same, with the second byte stalled for three cycles.
        startOp(256'hDEADBEEF, 32'h100, 6'd4);
        pushWr(1, 32'h100, 8'hDE);
        pushWr(5, 32'h101, 8'hAD);
        pushWr(6, 32'h102, 8'hBE);
        pushWr(7, 32'h103, 8'hEF);
        pushDone(8);
        tick();
        we = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            memReady = !(i >= 2 && i <= 4);
            if (i == 3) chk("busy stalled", 64'(busy), 64'd1);
            tick();
        end
        memReady = 1'b1;
        drain("stall", 20);

        // Zero-length store.
        startOp(256'h55, 32'h40, 6'd0);
        pushDone(1);
        tick();
        we = 1'b0;
        chk("n0 busy", 64'(busy), 64'd0);
        chk("n0 memWE", 64'(memWE), 64'd0);
        drain("n0", 10);

        // Only the low N bytes are sent.
        startOp(256'h0123456789, 32'h80, 6'd3);
        pushWr(1, 32'h80, 8'h45);
        pushWr(2, 32'h81, 8'h67);
        pushWr(3, 32'h82, 8'h89);
        pushDone(4);
        tick();
        we = 1'b0;
        drain("low bytes", 20);

        // Clamp to 32 bytes with the address wrapping past zero.
        for (int i = 0; i < 32; i++) ramp[8*i +: 8] = 8'(i);
        startOp(ramp, 32'hFFFFFFF0, 6'd40);
        for (int i = 0; i < 32; i++) pushWr(i + 1, 32'hFFFFFFF0 + 32'(i), 8'(31 - i));
        pushDone(33);
        tick();
        we = 1'b0;
        drain("clamp wrap", 60);

        // Rising we while in DONE must not start another operation.
        startOp(256'hC3, 32'h500, 6'd1);
        pushWr(1, 32'h500, 8'hC3);
        pushDone(2);
        tick();
        we = 1'b0;
        tick();
        we = 1'b1;
        tick(4);
        we = 1'b0;
        drain("we in done", 10);

        // Reset after two of four bytes have been accepted.
        startOp(256'hDEADBEEF, 32'h300, 6'd4);
        pushWr(1, 32'h300, 8'hDE);
        pushWr(2, 32'h301, 8'hAD);
        tick();
        we = 1'b0;
        tick(2);
        reset = 1'b1;
        memReady = 1'b0;
        tick();
        chk("reset mid memWE", 64'(memWE), 64'd0);
        chk("reset mid busy", 64'(busy), 64'd0);
        chk("reset mid done", 64'(done), 64'd0);
        reset = 1'b0;
        memReady = 1'b1;
        drain("reset mid", 5);

        startOp(256'hDEADBEEF, 32'h400, 6'd4);
        pushWr(1, 32'h400, 8'hDE);
        pushWr(2, 32'h401, 8'hAD);
        pushWr(3, 32'h402, 8'hBE);
        pushWr(4, 32'h403, 8'hEF);
        pushDone(5);
        tick();
        we = 1'b0;
        drain("after reset", 20);

        // Reset and start together: reset wins.
        reset = 1'b1;
        we = 1'b1;
        src = 256'hFF;
        byteCount = 6'd1;
        tick();
        reset = 1'b0;
        we = 1'b0;
        tick();
        chk("reset+start busy", 64'(busy), 64'd0);
        drain("reset+start", 5);

        // we held high with src changing mid-operation, then a fresh edge.
        startOp(256'h11223344, 32'h200, 6'd4);
        pushWr(1, 32'h200, 8'h11);
        pushWr(2, 32'h201, 8'h22);
        pushWr(3, 32'h202, 8'h33);
        pushWr(4, 32'h203, 8'h44);
        pushDone(5);
        tick();
        for (int i = 1; i < 20; i++) begin
            if (i == 2) begin
                src = 256'hAABBCCDD;
                baseAddr = 32'h900;
                byteCount = 6'd2;
            end
            tick();
        end
        we = 1'b0;
        chk("held sb empty", 64'(sb.size()), 64'd0);
        tick();
        startOp(256'h5566, 32'h210, 6'd2);
        pushWr(1, 32'h210, 8'h55);
        pushWr(2, 32'h211, 8'h66);
        pushDone(3);
        tick();
        we = 1'b0;
        drain("second edge", 20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
